// File: rtl/conv_pkg.sv
// Shared types and helpers for the conv_core_mode convolution engine:
// output-mode and FSM state encodings plus the output-range calculation.
package conv_pkg;

    typedef enum logic [1:0] {
        MODE_FULL  = 2'd0,
        MODE_SAME  = 2'd1,
        MODE_VALID = 2'd2
    } mode_e;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CHECK = 3'd1,
        SETUP = 3'd2,
        MAC   = 3'd3,
        DRAIN = 3'd4,
        WRITE = 3'd5,
        FIN   = 3'd6
    } state_e;

    typedef struct packed {
        logic [31:0] len;
        logic [31:0] k0;
    } out_range_t;

    // Number of output samples and the first k index for a given mode.
    function automatic out_range_t conv_out_range(input logic [1:0] mode,
                                                  input logic [31:0] sx,
                                                  input logic [31:0] sy);
        out_range_t r;
        r.len = 32'd0;
        r.k0  = 32'd0;
        case (mode)
            MODE_FULL: begin
                r.len = sx + sy - 32'd1;
                r.k0  = 32'd0;
            end
            MODE_SAME: begin
                r.len = sx;
                r.k0  = (sy - 32'd1) >> 32'd1;
            end
            MODE_VALID: begin
                r.len = sx - sy + 32'd1;
                r.k0  = sy - 32'd1;
            end
            default: begin
                r.len = 32'd0;
                r.k0  = 32'd0;
            end
        endcase
        return r;
    endfunction

endpackage

// File: rtl/conv_mac.sv
// Registered multiply-accumulate for conv_core_mode, with the reduction of the
// accumulator to DATA_W bits (saturating when CONV_SAT_EN is defined).
module conv_mac
    import conv_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ACC_W  = 70
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              en,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [DATA_W-1:0] res
`ifdef CONV_SAT_EN
    ,
    output logic              res_sat
`endif
);

    logic [2*DATA_W-1:0] prod_s;
    logic [ACC_W-1:0]    sum_s;
    logic [ACC_W-1:0]    acc_r;
    logic [DATA_W-1:0]   res_next_s;
    logic [DATA_W-1:0]   res_r;
`ifdef CONV_SAT_EN
    logic                ovf_s;
    logic                sat_r;
`endif

    // Next accumulator value and its DATA_W-wide view.
    always_comb begin
        prod_s = a * b;
        sum_s  = acc_r + ACC_W'(prod_s);
`ifdef CONV_SAT_EN
        ovf_s = (sum_s > ACC_W'({DATA_W{1'b1}}));
        if (ovf_s) begin
            res_next_s = {DATA_W{1'b1}};
        end else begin
            res_next_s = sum_s[DATA_W-1:0];
        end
`else
        res_next_s = sum_s[DATA_W-1:0];
`endif
    end

    // The reduced result is registered alongside the sum so it is ready the cycle after the last product.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_r <= {ACC_W{1'b0}};
            res_r <= {DATA_W{1'b0}};
`ifdef CONV_SAT_EN
            sat_r <= 1'b0;
`endif
        end else if (clr) begin
            acc_r <= {ACC_W{1'b0}};
        end else if (en) begin
            acc_r <= sum_s;
            res_r <= res_next_s;
`ifdef CONV_SAT_EN
            sat_r <= ovf_s;
`endif
        end
    end

    assign res = res_r;
`ifdef CONV_SAT_EN
    assign res_sat = sat_r;
`endif

endmodule

// File: rtl/conv_core_mode.sv
// 1-D convolution engine (FULL/SAME/VALID) driving external X/Y/Z RAMs.
// Optional saturating output and sticky `sat` status when CONV_SAT_EN is defined.
module conv_core_mode
    import conv_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 6,
    parameter int SIZE_W  = ADDR_W + 1,
    parameter int ZADDR_W = ADDR_W + 1,
    parameter int ACC_W   = 2 * DATA_W + ADDR_W
) (
    input  logic               clk,
    input  logic               rst_a,
    input  logic               start,
    input  logic [1:0]         mode,
    input  logic [SIZE_W-1:0]  size_x,
    input  logic [SIZE_W-1:0]  size_y,
    output logic               x_rd,
    output logic [ADDR_W-1:0]  x_addr,
    input  logic [DATA_W-1:0]  x_data,
    output logic               y_rd,
    output logic [ADDR_W-1:0]  y_addr,
    input  logic [DATA_W-1:0]  y_data,
    output logic               z_wr,
    output logic [ZADDR_W-1:0] z_addr,
    output logic [DATA_W-1:0]  z_data,
    output logic [ZADDR_W-1:0] z_len,
    output logic               busy,
    output logic               done,
    output logic               err
`ifdef CONV_SAT_EN
    ,
    output logic               sat
`endif
);

    localparam int CW = ZADDR_W + 1;
    localparam logic [SIZE_W-1:0]  MAX_LEN = SIZE_W'(64'd1 << ADDR_W);
    localparam logic [CW-1:0]      ONE_C   = CW'(1'b1);
    localparam logic [ZADDR_W-1:0] ONE_Z   = ZADDR_W'(1'b1);
    localparam logic [ADDR_W-1:0]  ONE_A   = ADDR_W'(1'b1);

    state_e             state_r, state_next_s;
    logic [1:0]         mode_r;
    logic [SIZE_W-1:0]  sx_r, sy_r;
    logic [ZADDR_W-1:0] k_r, n_r, len_r, last_s;
    logic [ADDR_W-1:0]  i_r, hi_r, ya_r;
    logic               rd_r, rd_d_r;
    logic               z_wr_r, busy_r, done_r, err_r;
    logic [ZADDR_W-1:0] z_addr_r, z_len_r;
    logic               cfg_err_s, mac_clr_s;
    out_range_t         rng_s;
    logic [CW-1:0]      k_ext_s, sx_ext_s, sy_ext_s, i_lo_s, i_hi_s;
`ifdef CONV_SAT_EN
    logic               mac_sat_s;
    logic               sat_r;
`endif

    // Configuration check, output range and per-sample index bounds.
    always_comb begin
        cfg_err_s = (sx_r == {SIZE_W{1'b0}}) || (sy_r == {SIZE_W{1'b0}}) ||
                    (sx_r > MAX_LEN) || (sy_r > MAX_LEN) ||
                    (mode_r == 2'd3) ||
                    ((mode_r == MODE_VALID) && (sx_r < sy_r));
        rng_s    = conv_out_range(mode_r, 32'(sx_r), 32'(sy_r));
        last_s   = len_r - ONE_Z;
        k_ext_s  = CW'(k_r);
        sx_ext_s = CW'(sx_r);
        sy_ext_s = CW'(sy_r);
        // i runs over max(0, k-SY+1) .. min(k, SX-1)
        if (k_ext_s + ONE_C > sy_ext_s) begin
            i_lo_s = k_ext_s + ONE_C - sy_ext_s;
        end else begin
            i_lo_s = {CW{1'b0}};
        end
        if (k_ext_s < sx_ext_s) begin
            i_hi_s = k_ext_s;
        end else begin
            i_hi_s = sx_ext_s - ONE_C;
        end
        mac_clr_s = (state_r == WRITE) || (state_r == CHECK);
    end

    // FSM state register.
    always_ff @(posedge clk or posedge rst_a) begin
        if (rst_a) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (start) begin
                    state_next_s = CHECK;
                end else begin
                    state_next_s = IDLE;
                end
            end
            CHECK: begin
                if (cfg_err_s) begin
                    state_next_s = FIN;
                end else begin
                    state_next_s = SETUP;
                end
            end
            SETUP: state_next_s = MAC;
            MAC: begin
                if (i_r == hi_r) begin
                    state_next_s = DRAIN;
                end else begin
                    state_next_s = MAC;
                end
            end
            DRAIN: state_next_s = WRITE;
            WRITE: begin
                if (n_r == last_s) begin
                    state_next_s = FIN;
                end else begin
                    state_next_s = SETUP;
                end
            end
            FIN:     state_next_s = IDLE;
            default: state_next_s = IDLE;
        endcase
    end

    // Job registers, address generation and registered status/port outputs.
    always_ff @(posedge clk or posedge rst_a) begin
        if (rst_a) begin
            mode_r   <= 2'd0;
            sx_r     <= {SIZE_W{1'b0}};
            sy_r     <= {SIZE_W{1'b0}};
            k_r      <= {ZADDR_W{1'b0}};
            n_r      <= {ZADDR_W{1'b0}};
            len_r    <= {ZADDR_W{1'b0}};
            i_r      <= {ADDR_W{1'b0}};
            hi_r     <= {ADDR_W{1'b0}};
            ya_r     <= {ADDR_W{1'b0}};
            rd_r     <= 1'b0;
            rd_d_r   <= 1'b0;
            z_wr_r   <= 1'b0;
            z_addr_r <= {ZADDR_W{1'b0}};
            z_len_r  <= {ZADDR_W{1'b0}};
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
            err_r    <= 1'b0;
`ifdef CONV_SAT_EN
            sat_r    <= 1'b0;
`endif
        end else begin
            rd_d_r <= rd_r;
            done_r <= 1'b0;
            z_wr_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (start) begin
                        mode_r  <= mode;
                        sx_r    <= size_x;
                        sy_r    <= size_y;
                        busy_r  <= 1'b1;
                        err_r   <= 1'b0;
                        z_len_r <= {ZADDR_W{1'b0}};
`ifdef CONV_SAT_EN
                        sat_r   <= 1'b0;
`endif
                    end
                end
                CHECK: begin
                    if (cfg_err_s) begin
                        err_r  <= 1'b1;
                        busy_r <= 1'b0;
                        done_r <= 1'b1;
                    end else begin
                        len_r <= ZADDR_W'(rng_s.len);
                        k_r   <= ZADDR_W'(rng_s.k0);
                        n_r   <= {ZADDR_W{1'b0}};
                    end
                end
                SETUP: begin
                    i_r  <= ADDR_W'(i_lo_s);
                    hi_r <= ADDR_W'(i_hi_s);
                    ya_r <= ADDR_W'(k_ext_s - i_lo_s);
                    rd_r <= 1'b1;
                end
                MAC: begin
                    if (i_r == hi_r) begin
                        rd_r <= 1'b0;
                    end else begin
                        i_r  <= i_r + ONE_A;
                        ya_r <= ya_r - ONE_A;
                    end
                end
                DRAIN: begin
                    z_wr_r   <= 1'b1;
                    z_addr_r <= n_r;
                end
                WRITE: begin
`ifdef CONV_SAT_EN
                    sat_r <= sat_r | mac_sat_s;
`endif
                    if (n_r == last_s) begin
                        busy_r  <= 1'b0;
                        done_r  <= 1'b1;
                        z_len_r <= len_r;
                    end else begin
                        n_r <= n_r + ONE_Z;
                        k_r <= k_r + ONE_Z;
                    end
                end
                FIN: begin
                    busy_r <= 1'b0;
                end
                default: begin
                    rd_r <= 1'b0;
                end
            endcase
        end
    end

    conv_mac #(
        .DATA_W(DATA_W),
        .ACC_W (ACC_W)
    ) u_mac (
        .clk    (clk),
        .rst    (rst_a),
        .clr    (mac_clr_s),
        .en     (rd_d_r),
        .a      (x_data),
        .b      (y_data),
        .res    (z_data)
`ifdef CONV_SAT_EN
        ,
        .res_sat(mac_sat_s)
`endif
    );

    assign x_rd   = rd_r;
    assign y_rd   = rd_r;
    assign x_addr = i_r;
    assign y_addr = ya_r;
    assign z_wr   = z_wr_r;
    assign z_addr = z_addr_r;
    assign z_len  = z_len_r;
    assign busy   = busy_r;
    assign done   = done_r;
    assign err    = err_r;
`ifdef CONV_SAT_EN
    assign sat    = sat_r;
`endif

endmodule

// File: tb/tb_conv_core_mode.sv
// Scoreboard bench for conv_core_mode: directed jobs push expected Z writes and
// completion status into queues; a negedge monitor pops and compares them.
module tb_conv_core_mode;

    logic        clk = 1'b0;
    logic        rst_a = 1'b1;
    logic        start = 1'b0;
    logic [1:0]  mode = 2'd0;
    logic [6:0]  size_x = 7'd0, size_y = 7'd0;
    logic        x_rd, y_rd, z_wr, busy, done, err;
    logic [5:0]  x_addr, y_addr;
    logic [31:0] x_data = 32'd0, y_data = 32'd0, z_data;
    logic [6:0]  z_addr, z_len;
`ifdef CONV_SAT_EN
    logic        sat;
`endif

    always #5 clk = ~clk;

    conv_core_mode dut (
        .clk(clk), .rst_a(rst_a), .start(start), .mode(mode),
        .size_x(size_x), .size_y(size_y),
        .x_rd(x_rd), .x_addr(x_addr), .x_data(x_data),
        .y_rd(y_rd), .y_addr(y_addr), .y_data(y_data),
        .z_wr(z_wr), .z_addr(z_addr), .z_data(z_data),
        .z_len(z_len), .busy(busy), .done(done), .err(err)
`ifdef CONV_SAT_EN
        , .sat(sat)
`endif
    );

    logic [31:0] xmem [64];
    logic [31:0] ymem [64];

    // Synchronous X/Y RAM models with one-cycle read latency.
    always @(posedge clk) begin
        if (x_rd) x_data <= xmem[x_addr];
        if (y_rd) y_data <= ymem[y_addr];
    end

    typedef struct { int unsigned addr; logic [31:0] data; } wr_t;
    typedef struct { int unsigned len; bit err; bit sat; } dn_t;
    wr_t exp_q[$];
    dn_t done_q[$];
    logic [31:0] xq[$], yq[$], eq[$];
    bit exp_sat = 1'b0;
    int errors = 0, checks = 0;
    int done_cnt = 0, wr_cnt = 0, mem_cnt = 0, overlap_cnt = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: compares every Z write and every done pulse with the scoreboard.
    always @(negedge clk) begin
        wr_t w;
        dn_t d;
        if (x_rd || y_rd || z_wr) mem_cnt++;
        if ((x_rd || y_rd) && z_wr) overlap_cnt++;
        if (z_wr) begin
            wr_cnt++;
            if (exp_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_zwr: got addr %0d data %0h expected no write", z_addr, z_data);
            end else begin
                w = exp_q.pop_front();
                check("z_addr", 64'(z_addr), 64'(w.addr));
                check("z_data", 64'(z_data), 64'(w.data));
            end
        end
        if (done) begin
            done_cnt++;
            if (done_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_done: got done=1 expected 0");
            end else begin
                d = done_q.pop_front();
                check("z_len", 64'(z_len), 64'(d.len));
                check("err", 64'(err), 64'(d.err));
                check("busy_at_done", 64'(busy), 64'd0);
`ifdef CONV_SAT_EN
                check("sat", 64'(sat), 64'(d.sat));
`endif
            end
        end
    end

    task automatic load_mems();
        for (int i = 0; i < xq.size(); i++) xmem[i] = xq[i];
        for (int i = 0; i < yq.size(); i++) ymem[i] = yq[i];
    endtask

    task automatic pulse_start(input logic [1:0] m, input int sx, input int sy);
        @(posedge clk); #1;
        mode = m; size_x = 7'(sx); size_y = 7'(sy); start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic run(input logic [1:0] m, input int sx, input int sy,
                       input bit exp_err, input bit poke);
        int d0;
        int mc;
        dn_t d;
        load_mems();
        for (int n = 0; n < eq.size(); n++) exp_q.push_back('{n, eq[n]});
        d.len = exp_err ? 0 : eq.size();
        d.err = exp_err;
        d.sat = exp_sat;
        done_q.push_back(d);
        d0 = done_cnt;
        mc = mem_cnt;
        pulse_start(m, sx, sy);
        if (poke) begin
            repeat (4) @(posedge clk);
            #1;
            check("busy_during_run", 64'(busy), 64'd1);
            mode = 2'd3; size_x = 7'd0; size_y = 7'd0; start = 1'b1;
            @(posedge clk); #1;
            start = 1'b0;
        end
        for (int c = 0; c < 3000 && done_cnt == d0; c++) @(posedge clk);
        if (done_cnt == d0) begin
            checks++; errors++;
            $display("FAIL done_timeout: got no done expected done within 3000 cycles");
        end
        @(negedge clk);
        check("pending_writes", 64'(exp_q.size()), 64'd0);
        if (exp_err) check("err_mem_access", 64'(mem_cnt - mc), 64'd0);
        repeat (2) @(posedge clk);
    endtask

    // Direct-from-definition FULL reference: sum over all (i, j) with i+j == k.
    task automatic model_full(input int sx, input int sy);
        longint unsigned s;
        eq.delete();
        for (int k = 0; k <= sx + sy - 2; k++) begin
            s = 0;
            for (int i = 0; i < sx; i++)
                for (int j = 0; j < sy; j++)
                    if (i + j == k) s = s + longint'(xq[i]) * longint'(yq[j]);
            eq.push_back(s[31:0]);
        end
    endtask

    task automatic rand_vectors(input int n);
        xq.delete(); yq.delete();
        for (int i = 0; i < n; i++) begin
            xq.push_back(32'($urandom_range(99)));
            yq.push_back(32'($urandom_range(99)));
        end
    endtask

    initial begin
        int w0;
        int d0;
        int c;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_err", 64'(err), 64'd0);
        check("rst_zwr", 64'(z_wr), 64'd0);
        check("rst_xrd", 64'(x_rd), 64'd0);
        check("rst_zlen", 64'(z_len), 64'd0);
        rst_a = 1'b0;

        xq = {32'd1, 32'd2, 32'd3}; yq = {32'd1, 32'd1};
        eq = {32'd1, 32'd3, 32'd5, 32'd3};
        run(2'd0, 3, 2, 1'b0, 1'b1);

        yq = {32'd1, 32'd1, 32'd1};
        eq = {32'd3, 32'd6, 32'd5};
        run(2'd1, 3, 3, 1'b0, 1'b0);

        yq = {32'd1, 32'd1};
        eq = {32'd1, 32'd3, 32'd5};
        run(2'd1, 3, 2, 1'b0, 1'b0);

        xq = {32'd1, 32'd2, 32'd3, 32'd4};
        eq = {32'd3, 32'd5, 32'd7};
        run(2'd2, 4, 2, 1'b0, 1'b0);

        eq.delete();
        run(2'd2, 2, 3, 1'b1, 1'b0);
        run(2'd3, 3, 2, 1'b1, 1'b0);
        run(2'd0, 0, 2, 1'b1, 1'b0);
        run(2'd0, 3, 65, 1'b1, 1'b0);

        xq = {32'hFFFF_FFFF, 32'd1}; yq = {32'd2};
`ifdef CONV_SAT_EN
        eq = {32'hFFFF_FFFF, 32'd2};
        exp_sat = 1'b1;
`else
        eq = {32'hFFFF_FFFE, 32'd2};
`endif
        run(2'd0, 2, 1, 1'b0, 1'b0);
        exp_sat = 1'b0;

        xq = {32'd7}; yq = {32'd6}; eq = {32'd42};
        run(2'd0, 1, 1, 1'b0, 1'b0);

        xq.delete(); yq.delete(); eq.delete();
        for (int i = 0; i < 64; i++) begin
            xq.push_back(32'(i));
            eq.push_back(32'(3 * i));
        end
        yq = {32'd3};
        run(2'd0, 64, 1, 1'b0, 1'b0);

        xq.delete(); yq.delete();
        for (int i = 0; i < 64; i++) begin
            xq.push_back(32'd1);
            yq.push_back(32'd1);
        end
        eq = {32'd64};
        run(2'd2, 64, 64, 1'b0, 1'b0);

        rand_vectors(10);
        model_full(10, 10);
        run(2'd0, 10, 10, 1'b0, 1'b0);

        // Abort a job in the middle of a MAC burst.
        rand_vectors(10);
        load_mems();
        model_full(10, 10);
        for (int n = 0; n < eq.size(); n++) exp_q.push_back('{n, eq[n]});
        pulse_start(2'd0, 10, 10);
        w0 = wr_cnt;
        c = 0;
        while (c < 500 && !(wr_cnt >= w0 + 2 && x_rd)) begin
            @(posedge clk); #1;
            c++;
        end
        check("abort_reached_mac", 64'(x_rd), 64'd1);
        rst_a = 1'b1;
        #1;
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_zwr", 64'(z_wr), 64'd0);
        exp_q.delete();
        done_q.delete();
        w0 = wr_cnt;
        d0 = done_cnt;
        repeat (3) @(posedge clk);
        #1 rst_a = 1'b0;
        repeat (30) @(posedge clk);
        #1;
        check("abort_no_writes", 64'(wr_cnt - w0), 64'd0);
        check("abort_no_done", 64'(done_cnt - d0), 64'd0);
        check("abort_idle_busy", 64'(busy), 64'd0);

        rand_vectors(10);
        model_full(10, 10);
        run(2'd0, 10, 10, 1'b0, 1'b0);

        check("rw_overlap", 64'(overlap_cnt), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/conv_core_mode.md
Name: conv_core_mode

Overview:
- Parametrised 1-D discrete convolution engine; next generation of the fixed 32-bit, full-mode-only convolution IP core.
- Adds generic data/address widths, three output modes (full/same/valid), a pipelined single-MAC datapath, error reporting and an output-length report.
- Sits behind the AIP wrapper: X and Y input memories and Z output memory are external synchronous RAMs; size and mode come from the wrapper's config register; done feeds the wrapper's interrupt/status logic.

Parameters:
- DATA_W, 32, unsigned sample width for X, Y and Z.
- ADDR_W, 6, X/Y memory address width; maximum input length is 2**ADDR_W.
- SIZE_W, ADDR_W+1, width of the size_x/size_y inputs.
- ZADDR_W, ADDR_W+1, Z memory address width; holds up to 2*2**ADDR_W-1 results.
- ACC_W, 2*DATA_W+ADDR_W, accumulator width; guarantees no internal overflow.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst_a  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle start pulse; ignored while busy=1.
- mode  in  2  0=FULL, 1=SAME, 2=VALID, 3=reserved; sampled at start.
- size_x  in  SIZE_W  number of X samples (SX); sampled at start.
- size_y  in  SIZE_W  number of Y samples (SY); sampled at start.
- x_rd / x_addr / x_data  out 1 / out ADDR_W / in DATA_W  X read port; data valid exactly one cycle after x_rd.
- y_rd / y_addr / y_data  out 1 / out ADDR_W / in DATA_W  Y read port; same one-cycle latency.
- z_wr / z_addr / z_data  out 1 / out ZADDR_W / out DATA_W  Z write port; one write per output sample.
- z_len  out  ZADDR_W  number of Z samples written in the last run; valid when done=1, held until the next start.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle completion pulse.
- err  out  1  high with done when the configuration was rejected; held until the next start.

Behaviour:
- Reset: all outputs 0; FSM in IDLE; accumulator and counters cleared. Reset mid-run aborts immediately; no further Z writes.
- Definitions: z[k] = sum over i of x[i]*y[k-i], for max(0,k-SY+1) <= i <= min(k,SX-1).
  - FULL: k = 0..SX+SY-2; length SX+SY-1.
  - SAME: k = off..off+SX-1, with off = (SY-1)>>1; length SX.
  - VALID: k = SY-1..SX-1; length SX-SY+1.
  - In every mode, output sample n is written to z_addr = n (starts at 0).
- Error check, performed in CHECK: err=1 if SX==0, SY==0, SX or SY > 2**ADDR_W, mode==3, or (VALID and SX<SY). On error: no memory access, z_len=0, done pulses 1 cycle after CHECK.
- FSM:
  - IDLE -> CHECK on start (latch mode and sizes).
  - CHECK -> FIN on error; otherwise -> SETUP.
  - SETUP computes the i range for the current k, then -> MAC.
  - MAC issues one x_rd/y_rd pair per cycle (x_addr=i, y_addr=k-i). The read data are multiplied and added into the accumulator in the following cycle, giving one product per cycle.
  - After the last read, DRAIN waits one cycle for the final product, then -> WRITE.
  - WRITE asserts z_wr for one cycle with z_addr=n and z_data = accumulator reduced to DATA_W. It then clears the accumulator and goes to SETUP for the next k, or to FIN after the last sample.
  - FIN pulses done, drops busy and returns to IDLE.
- Latency per output sample = (number of terms) + 3 cycles (SETUP + DRAIN + WRITE).
- Products are full 2*DATA_W unsigned. Accumulation is in ACC_W bits.
- Reduction to DATA_W truncates to the low bits, except when the optional saturation feature below is compiled in.
- start while busy: ignored, with no effect on the running job. Reads of X/Y and writes to Z never overlap within the core.

Optional Feature:
- Macro CONV_SAT_EN.
- Defined: if the accumulator exceeds 2**DATA_W-1, z_data saturates to all ones. A sticky status output `sat` (1 bit) is set for the run if any sample saturated; it is cleared at start.
- Undefined: plain truncation to the low DATA_W bits; the `sat` port is absent.

Decomposition:
- Package conv_pkg holds:
  - mode enum (MODE_FULL, MODE_SAME, MODE_VALID);
  - FSM state enum (IDLE, CHECK, SETUP, MAC, DRAIN, WRITE, FIN);
  - a function computing output length and start index k0 from mode/SX/SY.
- One sub-module, conv_mac: registered multiply-accumulate with clear and enable, parametrised on DATA_W/ACC_W, containing the saturation logic.
- The FSM and address generation stay in conv_core_mode.

Test Plan:
- FULL, x=[1,2,3], y=[1,1] -> Z writes [1,3,5,3], z_len=4, err=0, done once.
- SAME, x=[1,2,3], y=[1,1,1] -> Z writes [3,6,5], z_len=3.
- VALID, x=[1,2,3,4], y=[1,1] -> Z writes [3,5,7], z_len=3. Then VALID with SX=2, SY=3 -> err=1, no x_rd/y_rd/z_wr, z_len=0.
- DATA_W=8, FULL, x=[200], y=[2] -> z_data=0x90. With CONV_SAT_EN -> z_data=0xFF and sat=1.
- Regression against the previous generation: DATA_W=32, FULL, SX=SY=10, random inputs 0..99 -> 19 results match the C reference model bit-exactly.
- Robustness:
  - start pulse during busy -> ignored, results unchanged.
  - rst_a asserted mid-MAC -> busy=0, no further z_wr.
  - a new run afterwards gives correct results.
